sm5_w_shifter: RTL and testbench

Parametrised W′/W digit shift-register and LCD scan unit for the SM5-family CPU cores. It executes the SM5a W-register instructions WR, WS, DTW, PDTW, TW and PTW for any register length, and adds a free-running digit scanner that presents W to the LCD segment drivers one nibble per scan slot. It sits beside the instruction decoder. The decoder issues single-cycle commands with the current Acc, CN and m′ values, and the LCD front end consumes the scan outputs.

---
 rtl/sm5_w_shifter.sv | 149 ++++++++++++++
 tb/tb_sm5_w_shifter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm5_w_shifter.sv
// sm5_w_shifter: SM5 W'/W digit shift register plus free-running LCD digit scanner.
// Latency: commands show on w_prime_out/w_out one cycle after the command edge; scan outputs change on prescaler wrap.
// Backpressure: none; every cmd_valid cycle is executed, the scanner never stalls.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid, cmd_op[2:0]        command strobe and opcode (NOP WR WS DTW PDTW TW PTW CLR)
//   acc[3:0], lcd_cn, m_prime     operands from the decoder (Acc, CN, m')
//   blank                         forces scan_strobe/scan_seg to zero, combinationally
//   w_prime_out, w_out            W' and W, position i at bits [4i+3:4i]
//   scan_idx, scan_strobe         current digit and its one-hot enable
//   scan_seg, frame_start         nibble for scan_idx, one-cycle pulse when scan_idx wraps to 0
module sm5_w_shifter #(
  parameter int W_LENGTH = 9,
  parameter int SCAN_DIV = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  input  logic [2:0]                    cmd_op,
  input  logic [3:0]                    acc,
  input  logic                          lcd_cn,
  input  logic                          m_prime,
  input  logic                          blank,
  output logic [4*W_LENGTH-1:0]         w_prime_out,
  output logic [4*W_LENGTH-1:0]         w_out,
  output logic [$clog2(W_LENGTH)-1:0]   scan_idx,
  output logic [W_LENGTH-1:0]           scan_strobe,
  output logic [3:0]                    scan_seg,
  output logic                          frame_start
);

  localparam int L  = W_LENGTH;
  localparam int H  = L - 1;
  localparam int IW = $clog2(L);
  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_WR   = 3'd1,
    OP_WS   = 3'd2,
    OP_DTW  = 3'd3,
    OP_PDTW = 3'd4,
    OP_TW   = 3'd5,
    OP_PTW  = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  logic [L-1:0][3:0] r_wp;
  logic [L-1:0][3:0] r_w;
  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic [L-1:0]      r_strobe;
  logic [3:0]        r_seg;
  logic              r_frame;

  op_e               w_op;
  logic [3:0]        w_digit;
  logic [3:0]        w_shift_val;
  logic              w_wrap;
  logic [IW-1:0]     w_idx_nxt;

  // Segment-decoder PLA, indexed by {CN, Acc}.
  function automatic logic [3:0] pla_rom(input logic [4:0] a);
    logic [3:0] d;
    d = 4'h0;
    case (a)
      5'h00: d = 4'he;  5'h01: d = 4'h0;  5'h02: d = 4'hc;  5'h03: d = 4'h8;
      5'h04: d = 4'h2;  5'h05: d = 4'ha;  5'h06: d = 4'he;  5'h07: d = 4'h2;
      5'h08: d = 4'he;  5'h09: d = 4'ha;  5'h0a: d = 4'h0;  5'h0b: d = 4'h0;
      5'h0c: d = 4'h2;  5'h0d: d = 4'ha;  5'h0e: d = 4'h2;  5'h0f: d = 4'h2;
      5'h10: d = 4'hb;  5'h11: d = 4'h9;  5'h12: d = 4'h7;  5'h13: d = 4'hf;
      5'h14: d = 4'hd;  5'h15: d = 4'he;  5'h16: d = 4'he;  5'h17: d = 4'hb;
      5'h18: d = 4'hf;  5'h19: d = 4'hf;  5'h1a: d = 4'h4;  5'h1b: d = 4'h0;
      5'h1c: d = 4'hd;  5'h1d: d = 4'he;  5'h1e: d = 4'h4;  5'h1f: d = 4'h0;
      default: d = 4'h0;
    endcase
    return d;
  endfunction

  assign w_op    = op_e'(cmd_op);
  // m' only sets bit 0 on the CN=0 half of the PLA.
  assign w_digit = pla_rom({lcd_cn, acc}) | {3'b000, ~lcd_cn & m_prime};

  assign w_shift_val = (w_op == OP_WR) ? {1'b0, acc[2:0]} :
                       (w_op == OP_WS) ? {1'b1, acc[2:0]} : w_digit;

  // W'/W command execution.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_w  <= '0;
    end else if (cmd_valid) begin
      case (w_op)
        OP_WR, OP_WS, OP_DTW: begin
          for (int i = 0; i < H; i++) r_wp[i] <= r_wp[i+1];
          r_wp[H] <= w_shift_val;
        end
        OP_PDTW: begin
          r_wp[H-1] <= r_wp[H];
          r_wp[H]   <= w_digit;
        end
        OP_TW:  r_w <= r_wp;
        OP_PTW: begin
          r_w[H]   <= r_wp[H];
          r_w[H-1] <= r_wp[H-1];
        end
        OP_CLR: begin
          r_wp <= '0;
          r_w  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign w_wrap    = (r_presc == PW'(SCAN_DIV - 1));
  assign w_idx_nxt = (r_idx == IW'(H)) ? '0 : r_idx + IW'(1);

  // Scanner. r_w is read before this edge's command lands, so a TW on a
  // wrap edge leaves the previous nibble on scan_seg for that slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_strobe <= '0;
      r_seg    <= '0;
      r_frame  <= 1'b0;
    end else if (w_wrap) begin
      r_presc  <= '0;
      r_idx    <= w_idx_nxt;
      r_seg    <= r_w[w_idx_nxt];
      r_strobe <= L'(1) << w_idx_nxt;
      r_frame  <= (w_idx_nxt == '0);
    end else begin
      r_presc  <= r_presc + PW'(1);
      r_frame  <= 1'b0;
    end
  end

  assign w_prime_out = r_wp;
  assign w_out       = r_w;
  assign scan_idx    = r_idx;
  assign frame_start = r_frame;
  // Blanking gates the registered outputs without disturbing the scan position.
  assign scan_strobe = blank ? '0 : r_strobe;
  assign scan_seg    = blank ? 4'h0 : r_seg;

endmodule

// File: tb/tb_sm5_w_shifter.sv
module tb_sm5_w_shifter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] acc = 4'd0;
  logic       lcd_cn = 1'b0;
  logic       m_prime = 1'b0;
  logic       blank = 1'b0;

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Instance outputs: k=0 L9/DIV64, k=1 L9/DIV4, k=2 L2/DIV4, k=3 L16/DIV2
  logic [35:0] wp0, w0, wp1, w1;
  logic [7:0]  wp2, w2;
  logic [63:0] wp3, w3;
  logic [3:0]  idx0, idx1, idx3;
  logic [0:0]  idx2;
  logic [8:0]  st0, st1;
  logic [1:0]  st2;
  logic [15:0] st3;
  logic [3:0]  seg0, seg1, seg2, seg3;
  logic        fr0, fr1, fr2, fr3;

  sm5_w_shifter #(.W_LENGTH(9), .SCAN_DIV(64)) u0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .acc(acc),
    .lcd_cn(lcd_cn), .m_prime(m_prime), .blank(blank), .w_prime_out(wp0), .w_out(w0),
    .scan_idx(idx0), .scan_strobe(st0), .scan_seg(seg0), .frame_start(fr0));
  sm5_w_shifter #(.W_LENGTH(9), .SCAN_DIV(4)) u1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .acc(acc),
    .lcd_cn(lcd_cn), .m_prime(m_prime), .blank(blank), .w_prime_out(wp1), .w_out(w1),
    .scan_idx(idx1), .scan_strobe(st1), .scan_seg(seg1), .frame_start(fr1));
  sm5_w_shifter #(.W_LENGTH(2), .SCAN_DIV(4)) u2 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .acc(acc),
    .lcd_cn(lcd_cn), .m_prime(m_prime), .blank(blank), .w_prime_out(wp2), .w_out(w2),
    .scan_idx(idx2), .scan_strobe(st2), .scan_seg(seg2), .frame_start(fr2));
  sm5_w_shifter #(.W_LENGTH(16), .SCAN_DIV(2)) u3 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .acc(acc),
    .lcd_cn(lcd_cn), .m_prime(m_prime), .blank(blank), .w_prime_out(wp3), .w_out(w3),
    .scan_idx(idx3), .scan_strobe(st3), .scan_seg(seg3), .frame_start(fr3));

  logic [63:0] wp_o [4];
  logic [63:0] w_o  [4];
  logic [3:0]  idx_o[4];
  logic [15:0] st_o [4];
  logic [3:0]  seg_o[4];
  logic        fr_o [4];

  assign wp_o[0] = {28'b0, wp0};  assign w_o[0] = {28'b0, w0};
  assign wp_o[1] = {28'b0, wp1};  assign w_o[1] = {28'b0, w1};
  assign wp_o[2] = {56'b0, wp2};  assign w_o[2] = {56'b0, w2};
  assign wp_o[3] = wp3;           assign w_o[3] = w3;
  assign idx_o[0] = idx0;  assign idx_o[1] = idx1;  assign idx_o[2] = {3'b0, idx2};  assign idx_o[3] = idx3;
  assign st_o[0] = {7'b0, st0};  assign st_o[1] = {7'b0, st1};  assign st_o[2] = {14'b0, st2};  assign st_o[3] = st3;
  assign seg_o[0] = seg0;  assign seg_o[1] = seg1;  assign seg_o[2] = seg2;  assign seg_o[3] = seg3;
  assign fr_o[0] = fr0;  assign fr_o[1] = fr1;  assign fr_o[2] = fr2;  assign fr_o[3] = fr3;

  // ---------------- reference model ----------------
  function automatic int ln(input int k);
    case (k) 0: return 9; 1: return 9; 2: return 2; default: return 16; endcase
  endfunction
  function automatic int dv(input int k);
    case (k) 0: return 64; 1: return 4; 2: return 4; default: return 2; endcase
  endfunction

  function automatic int pla_ref(input logic cn, input logic [3:0] a, input logic m);
    logic [63:0] t;
    t = cn ? 64'hb97f_deeb_ff40_de40 : 64'he0c8_2ae2_ea00_2a22;
    return int'(t[60 - 4*int'(a) +: 4]) | ((!cn && m) ? 1 : 0);
  endfunction

  function automatic int shift_val();
    case (cmd_op)
      3'd1:    return int'(acc) & 7;
      3'd2:    return 8 | (int'(acc) & 7);
      default: return pla_ref(lcd_cn, acc, m_prime);
    endcase
  endfunction

  int mwp[4][16];
  int mw [4][16];
  int mseg[4];
  int cyc = 0;   // clock edges since reset release

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc <= 0;
      for (int k = 0; k < 4; k++) begin
        mseg[k] <= 0;
        for (int i = 0; i < 16; i++) begin
          mwp[k][i] <= 0;
          mw[k][i]  <= 0;
        end
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 4; k++) begin
        if ((cyc + 1) % dv(k) == 0) mseg[k] <= mw[k][((cyc + 1) / dv(k)) % ln(k)];
        if (cmd_valid) begin
          case (cmd_op)
            3'd1, 3'd2, 3'd3: begin
              for (int i = 0; i < 15; i++) if (i < ln(k) - 1) mwp[k][i] <= mwp[k][i+1];
              mwp[k][ln(k)-1] <= shift_val();
            end
            3'd4: begin
              mwp[k][ln(k)-2] <= mwp[k][ln(k)-1];
              mwp[k][ln(k)-1] <= pla_ref(lcd_cn, acc, m_prime);
            end
            3'd5: for (int i = 0; i < 16; i++) if (i < ln(k)) mw[k][i] <= mwp[k][i];
            3'd6: begin
              mw[k][ln(k)-1] <= mwp[k][ln(k)-1];
              mw[k][ln(k)-2] <= mwp[k][ln(k)-2];
            end
            3'd7: for (int i = 0; i < 16; i++) begin
              mwp[k][i] <= 0;
              mw[k][i]  <= 0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [63:0] pk(input int k, input bit sel_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ln(k); i++) r[4*i +: 4] = sel_w ? 4'(mw[k][i]) : 4'(mwp[k][i]);
    return r;
  endfunction

  function automatic int e_idx(input int k);
    return (cyc / dv(k)) % ln(k);
  endfunction
  function automatic logic [15:0] e_strobe(input int k);
    return (cyc >= dv(k) && !blank) ? (16'(1) << e_idx(k)) : 16'h0;
  endfunction
  function automatic logic [3:0] e_seg(input int k);
    return blank ? 4'h0 : 4'(mseg[k]);
  endfunction
  function automatic logic e_frame(input int k);
    return (cyc > 0) && (cyc % (dv(k) * ln(k)) == 0);
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic cn, input logic m);
    cmd_valid = 1'b1; cmd_op = op; acc = a; lcd_cn = cn; m_prime = m;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (wp_o[k] !== 64'h0 || w_o[k] !== 64'h0 || st_o[k] !== 16'h0 || seg_o[k] !== 4'h0 ||
          fr_o[k] !== 1'b0 || idx_o[k] !== 4'h0) begin
        errs++;
        $display("FAIL reset_vals k=%0d wp=%h w=%h st=%h seg=%h fr=%b idx=%h required all 0",
                 k, wp_o[k], w_o[k], st_o[k], seg_o[k], fr_o[k], idx_o[k]);
      end
    end
    reset_n = 1'b1;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      vecs++;
      if (st_o[0] !== e_strobe(0) || w_o[0] !== 64'h0) begin
        errs++;
        $display("FAIL reset_scan j=%0d strobe=%h required %h w=%h", j, st_o[0], e_strobe(0), w_o[0]);
      end
      if (j == 64) begin
        vecs++;
        if (idx_o[0] !== 4'd1 || st_o[0] !== 16'h0002) begin
          errs++;
          $display("FAIL first_wrap idx=%0d strobe=%h required 1 / 0002", idx_o[0], st_o[0]);
        end
      end
    end
  endtask

  task automatic test_wr_ws;
    issue(3'd7, 4'h0, 1'b0, 1'b0);
    issue(3'd1, 4'hF, 1'b0, 1'b0);
    issue(3'd2, 4'h2, 1'b0, 1'b0);
    vecs++;
    if (wp_o[1] !== 64'h0000_000A_7000_0000) begin
      errs++;
      $display("FAIL wr_ws wp=%h required a70000000", wp_o[1]);
    end
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (wp_o[k] !== pk(k, 0)) begin
        errs++;
        $display("FAIL wr_ws_model k=%0d wp=%h required %h", k, wp_o[k], pk(k, 0));
      end
    end
  endtask

  task automatic test_pla;
    issue(3'd7, 4'h0, 1'b0, 1'b0);
    issue(3'd3, 4'h3, 1'b0, 1'b1);
    vecs++;
    if (wp_o[1] !== 64'h0000_0009_0000_0000) begin
      errs++;
      $display("FAIL dtw wp=%h required 900000000", wp_o[1]);
    end
    issue(3'd4, 4'hA, 1'b1, 1'b1);
    vecs++;
    if (wp_o[1] !== 64'h0000_0004_9000_0000) begin
      errs++;
      $display("FAIL pdtw wp=%h required 490000000", wp_o[1]);
    end
    for (int n = 0; n < 64; n++) begin
      issue((n % 2 == 0) ? 3'd3 : 3'd4, 4'(n >> 2), n[1], 1'b1 ^ n[0] ^ n[5]);
      for (int k = 1; k < 4; k++) begin
        vecs++;
        if (wp_o[k] !== pk(k, 0)) begin
          errs++;
          $display("FAIL pla_sweep n=%0d k=%0d wp=%h required %h", n, k, wp_o[k], pk(k, 0));
        end
      end
    end
  endtask

  task automatic test_tw_ptw;
    issue(3'd7, 4'h0, 1'b0, 1'b0);
    for (int v = 1; v <= 7; v++) issue(3'd1, 4'(v), 1'b0, 1'b0);
    issue(3'd2, 4'h0, 1'b0, 1'b0);
    issue(3'd2, 4'h1, 1'b0, 1'b0);
    vecs++;
    if (wp_o[1] !== 64'h0000_0009_8765_4321) begin
      errs++;
      $display("FAIL fill wp=%h required 987654321", wp_o[1]);
    end
    issue(3'd6, 4'h0, 1'b0, 1'b0);
    vecs++;
    if (w_o[1] !== 64'h0000_0009_8000_0000) begin
      errs++;
      $display("FAIL ptw w=%h required 980000000", w_o[1]);
    end
    issue(3'd5, 4'h0, 1'b0, 1'b0);
    vecs++;
    if (w_o[1] !== 64'h0000_0009_8765_4321) begin
      errs++;
      $display("FAIL tw w=%h required 987654321", w_o[1]);
    end
  endtask

  task automatic test_scan;
    int last_fr;
    logic [3:0] old_seg;
    last_fr = -1;
    for (int j = 0; j < 110; j++) begin
      @(negedge clk);
      vecs++;
      if (idx_o[1] !== 4'(e_idx(1)) || st_o[1] !== e_strobe(1) || seg_o[1] !== e_seg(1) ||
          fr_o[1] !== e_frame(1)) begin
        errs++;
        $display("FAIL scan cyc=%0d idx=%0d st=%h seg=%h fr=%b required %0d %h %h %b", cyc,
                 idx_o[1], st_o[1], seg_o[1], fr_o[1], e_idx(1), e_strobe(1), e_seg(1), e_frame(1));
      end
      if (j >= 8) begin
        vecs++;
        if (seg_o[1] !== 4'(e_idx(1) + 1)) begin
          errs++;
          $display("FAIL scan_digit idx=%0d seg=%h required %h", idx_o[1], seg_o[1], 4'(e_idx(1) + 1));
        end
      end
      if (fr_o[1]) begin
        if (last_fr >= 0) begin
          vecs++;
          if (cyc - last_fr != 36) begin
            errs++;
            $display("FAIL frame_period got %0d required 36", cyc - last_fr);
          end
        end
        last_fr = cyc;
      end
    end
    vecs++;
    if (last_fr < 0) begin
      errs++;
      $display("FAIL frame_seen got none required a pulse");
    end
    // blanking acts in the same cycle
    blank = 1'b1;
    #1;
    vecs++;
    if (st_o[1] !== 16'h0 || seg_o[1] !== 4'h0) begin
      errs++;
      $display("FAIL blank st=%h seg=%h required 0 0", st_o[1], seg_o[1]);
    end
    repeat (5) @(negedge clk);
    vecs++;
    if (st_o[1] !== 16'h0 || idx_o[1] !== 4'(e_idx(1))) begin
      errs++;
      $display("FAIL blank_run st=%h idx=%0d required 0 %0d", st_o[1], idx_o[1], e_idx(1));
    end
    blank = 1'b0;
    // TW landing on a wrap edge
    issue(3'd7, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) issue(3'd2, 4'($urandom_range(0, 7)), 1'b0, 1'b0);
    for (int t = 0; t < 5 && (cyc % 4) != 3; t++) @(negedge clk);
    vecs++;
    if ((cyc % 4) != 3) begin
      errs++;
      $display("FAIL wrap_align timeout cyc=%0d", cyc);
    end
    issue(3'd5, 4'h0, 1'b0, 1'b0);
    old_seg = seg_o[1];
    vecs++;
    if (old_seg !== 4'h0 || w_o[1] !== pk(1, 1)) begin
      errs++;
      $display("FAIL tw_on_wrap seg=%h w=%h required 0 %h", old_seg, w_o[1], pk(1, 1));
    end
    repeat (4) @(negedge clk);
    vecs++;
    if (seg_o[1] !== e_seg(1) || seg_o[1] < 4'h8) begin
      errs++;
      $display("FAIL tw_next_slot seg=%h required %h", seg_o[1], e_seg(1));
    end
  endtask

  task automatic test_corner;
    bit seen;
    issue(3'd7, 4'h0, 1'b0, 1'b0);
    issue(3'd1, 4'h3, 1'b0, 1'b0);
    issue(3'd3, 4'h1, 1'b0, 1'b0);
    vecs++;
    if (wp_o[2] !== 64'h03) begin
      errs++;
      $display("FAIL l2_dtw wp=%h required 03", wp_o[2]);
    end
    issue(3'd7, 4'h0, 1'b0, 1'b0);
    issue(3'd1, 4'h3, 1'b0, 1'b0);
    issue(3'd4, 4'h1, 1'b0, 1'b0);
    vecs++;
    if (wp_o[2] !== 64'h03) begin
      errs++;
      $display("FAIL l2_pdtw wp=%h required 03", wp_o[2]);
    end
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (idx_o[3] == 4'd15) seen = 1'b1;
    end
    for (int t = 0; t < 3 && idx_o[3] == 4'd15; t++) @(negedge clk);
    vecs++;
    if (!seen || idx_o[3] !== 4'd0 || fr_o[3] !== 1'b1) begin
      errs++;
      $display("FAIL l16_wrap seen15=%b idx=%0d fr=%b required 1 0 1", seen, idx_o[3], fr_o[3]);
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 9; i++) issue(3'd2, 4'(i), 1'b0, 1'b0);
    issue(3'd5, 4'h0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (wp_o[k] !== 64'h0 || w_o[k] !== 64'h0 || st_o[k] !== 16'h0 || seg_o[k] !== 4'h0 ||
          fr_o[k] !== 1'b0 || idx_o[k] !== 4'h0) begin
        errs++;
        $display("FAIL mid_reset k=%0d wp=%h w=%h st=%h seg=%h idx=%h required all 0",
                 k, wp_o[k], w_o[k], st_o[k], seg_o[k], idx_o[k]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        vecs++;
        if (wp_o[k] !== pk(k, 0) || w_o[k] !== pk(k, 1)) begin
          errs++;
          $display("FAIL rnd_regs n=%0d k=%0d wp=%h w=%h required %h %h", n, k, wp_o[k], w_o[k],
                   pk(k, 0), pk(k, 1));
        end
        vecs++;
        if (idx_o[k] !== 4'(e_idx(k)) || st_o[k] !== e_strobe(k) || seg_o[k] !== e_seg(k) ||
            fr_o[k] !== e_frame(k)) begin
          errs++;
          $display("FAIL rnd_scan n=%0d k=%0d idx=%0d st=%h seg=%h fr=%b required %0d %h %h %b", n, k,
                   idx_o[k], st_o[k], seg_o[k], fr_o[k], e_idx(k), e_strobe(k), e_seg(k), e_frame(k));
        end
      end
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_op    = 3'($urandom_range(0, 7));
      // keep CLR rare so registers fill up
      if (cmd_op == 3'd7 && $urandom_range(0, 3) != 0) cmd_op = 3'd1;
      acc       = 4'($urandom_range(0, 15));
      lcd_cn    = 1'($urandom_range(0, 1));
      m_prime   = 1'($urandom_range(0, 1));
      blank     = ($urandom_range(0, 4) == 0);
    end
    cmd_valid = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wr_ws();
    test_pla();
    test_tw_ptw();
    test_scan();
    test_corner();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
